// File: rtl/signed_result_display_v.sv
// signed_result_display_v
// Output stage behind signed_calc_v. It captures an 8-bit result and converts
// it to sign plus three BCD digits with a multi-cycle double-dabble. The value
// is then scanned onto a 4-digit common-anode seven-segment display.
// Optional build macro: SIGNED_RESULT_ZERO_BLANK_EN enables leading-zero
// blanking of the hundreds and tens digits.
module signed_result_display_v #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_fu,
    input  logic       i_signed,
    input  logic       i_load,
    output logic       o_busy,
    output logic       o_done,
    output logic [6:0] o_seg,
    output logic [3:0] o_an,
    output logic       o_dp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Internal digit codes: 0..9 are numerals, plus two symbols.
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    state_t      state_reg, state_next;
    logic        neg_reg, neg_next;
    logic [7:0]  mag_reg, mag_next;
    logic [11:0] bcd_reg, bcd_next;
    logic [2:0]  step_reg, step_next;
    logic        done_reg, done_next;

    logic        disp_neg_reg, disp_neg_next;
    logic [3:0]  disp_hun_reg, disp_hun_next;
    logic [3:0]  disp_ten_reg, disp_ten_next;
    logic [3:0]  disp_unit_reg, disp_unit_next;

    logic [PW-1:0] presc_reg;
    logic [1:0]    idx_reg;
    logic [6:0]    seg_reg;
    logic [3:0]    an_reg;

    logic [11:0] bcd_adj;
    logic [19:0] dd_shifted;
    logic [7:0]  load_mag;
    logic        load_neg;
    logic        hun_blank;
    logic        ten_blank;
    logic [3:0]  digit_code;

    // Active-low gfedcba pattern for an internal digit code.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:       seg = 7'b1000000;
            4'd1:       seg = 7'b1111001;
            4'd2:       seg = 7'b0100100;
            4'd3:       seg = 7'b0110000;
            4'd4:       seg = 7'b0011001;
            4'd5:       seg = 7'b0010010;
            4'd6:       seg = 7'b0000010;
            4'd7:       seg = 7'b1111000;
            4'd8:       seg = 7'b0000000;
            4'd9:       seg = 7'b0010000;
            CODE_MINUS: seg = 7'b0111111;
            default:    seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: each BCD nibble of 5 or more gets +3 before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? bcd_reg[gi*4 +: 4] + 4'd3
                                        : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // The BCD register and the binary magnitude shift left together as one
    // 20-bit word. The top BCD bit never overflows because the value is at most 255.
    assign dd_shifted = {bcd_adj[10:0], mag_reg, 1'b0};

    // Magnitude fits in 8 bits: the worst case is -128, which gives 8'h80 = 128.
    assign load_neg = i_signed & i_fu[7];
    assign load_mag = load_neg ? (8'd0 - i_fu) : i_fu;

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            neg_reg       <= 1'b0;
            mag_reg       <= 8'd0;
            bcd_reg       <= 12'd0;
            step_reg      <= 3'd0;
            done_reg      <= 1'b0;
            disp_neg_reg  <= 1'b0;
            disp_hun_reg  <= 4'd0;
            disp_ten_reg  <= 4'd0;
            disp_unit_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            neg_reg       <= neg_next;
            mag_reg       <= mag_next;
            bcd_reg       <= bcd_next;
            step_reg      <= step_next;
            done_reg      <= done_next;
            disp_neg_reg  <= disp_neg_next;
            disp_hun_reg  <= disp_hun_next;
            disp_ten_reg  <= disp_ten_next;
            disp_unit_reg <= disp_unit_next;
        end
    end

    // Next-state and datapath: capture in IDLE, 8 shift steps in CONV, publish in DONE.
    always_comb begin
        state_next     = state_reg;
        neg_next       = neg_reg;
        mag_next       = mag_reg;
        bcd_next       = bcd_reg;
        step_next      = step_reg;
        done_next      = 1'b0;
        disp_neg_next  = disp_neg_reg;
        disp_hun_next  = disp_hun_reg;
        disp_ten_next  = disp_ten_reg;
        disp_unit_next = disp_unit_reg;
        case (state_reg)
            IDLE: begin
                if (i_load) begin
                    neg_next   = load_neg;
                    mag_next   = load_mag;
                    bcd_next   = 12'd0;
                    step_next  = 3'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                bcd_next  = dd_shifted[19:8];
                mag_next  = dd_shifted[7:0];
                step_next = step_reg + 3'd1;
                if (step_reg == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                disp_neg_next  = neg_reg;
                disp_hun_next  = bcd_reg[11:8];
                disp_ten_next  = bcd_reg[7:4];
                disp_unit_next = bcd_reg[3:0];
                done_next      = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SIGNED_RESULT_ZERO_BLANK_EN
    assign hun_blank = (disp_hun_reg == 4'd0);
    assign ten_blank = hun_blank && (disp_ten_reg == 4'd0);
`else
    assign hun_blank = 1'b0;
    assign ten_blank = 1'b0;
`endif

    // Select the code of the digit currently being scanned.
    always_comb begin
        digit_code = CODE_BLANK;
        case (idx_reg)
            2'd3: digit_code = disp_neg_reg ? CODE_MINUS : CODE_BLANK;
            2'd2: digit_code = hun_blank ? CODE_BLANK : disp_hun_reg;
            2'd1: digit_code = ten_blank ? CODE_BLANK : disp_ten_reg;
            default: digit_code = disp_unit_reg;
        endcase
    end

    // Scan prescaler and digit index, with registered anode and segment drive.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            presc_reg <= '0;
            idx_reg   <= 2'd0;
            an_reg    <= 4'b1110;
            seg_reg   <= 7'b1000000;
        end else begin
            if (presc_reg == PRESC_MAX) begin
                presc_reg <= '0;
                idx_reg   <= idx_reg + 2'd1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            an_reg  <= ~(4'b0001 << idx_reg);
            seg_reg <= seg_decode(digit_code);
        end
    end

    assign o_busy = (state_reg != IDLE);
    assign o_done = done_reg;
    assign o_seg  = seg_reg;
    assign o_an   = an_reg;
    assign o_dp   = 1'b1;

endmodule

// File: tb/tb_signed_result_display_v.sv
// Directed testbench for signed_result_display_v with a fast scan (SCAN_DIV=4).
module tb_signed_result_display_v;

`ifdef SIGNED_RESULT_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [6:0] BLK = 7'b1111111;
    localparam logic [6:0] MIN = 7'b0111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] fu;
    logic       sgn;
    logic       load;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int n_assert = 0;
    int n_fail   = 0;
    logic [6:0] seg_tab [10];

    signed_result_display_v #(.SCAN_DIV(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_fu     (fu),
        .i_signed (sgn),
        .i_load   (load),
        .o_busy   (busy),
        .o_done   (done),
        .o_seg    (seg),
        .o_an     (an),
        .o_dp     (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until digit d is enabled, then return its segments.
    task automatic read_digit(input int d, output logic [6:0] s);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        s     = 7'h00;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (an === want) begin
                found = 1'b1;
                s = seg;
            end
        end
        chk("scan_found", {31'd0, found}, 32'd1);
    endtask

    task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        logic [6:0] s;
        logic [6:0] exp [4];
        exp[3] = e3; exp[2] = e2; exp[1] = e1; exp[0] = e0;
        for (int d = 3; d >= 0; d--) begin
            read_digit(d, s);
            chk($sformatf("%s_dig%0d", tag, d), {25'd0, s}, {25'd0, exp[d]});
        end
        $display("display %s: checked 4 digits", tag);
    endtask

    // Load a value and check the busy window and the done pulse timing.
    task automatic do_load(input logic [7:0] v, input logic s, input string tag);
        int bc;
        @(negedge clk); fu = v; sgn = s; load = 1'b1;
        @(negedge clk); load = 1'b0;
        bc = 0;
        for (int c = 0; c < 9; c++) begin
            if (busy === 1'b1 && done === 1'b0) bc++;
            @(negedge clk);
        end
        chk({tag, "_busy9"}, bc, 9);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        $display("load %s: fu=%02h signed=%0b", tag, v, s);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        rst_n = 1'b0; fu = 8'h00; sgn = 1'b0; load = 1'b0;
        // Reset with a load request: reset wins.
        @(negedge clk); load = 1'b1; fu = 8'hFF;
        @(negedge clk); load = 1'b0; rst_n = 1'b1;
        chk("rst_an", {28'd0, an}, 32'h0000000E);
        chk("rst_seg", {25'd0, seg}, 32'h00000040);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        $display("reset: an=%b seg=%b busy=%b", an, seg, busy);

        // Scan stepping: index advances every 4 cycles, anode follows one cycle later.
        repeat (5) @(negedge clk);
        chk("scan_an1", {28'd0, an}, 32'h0000000D);
        repeat (4) @(negedge clk);
        chk("scan_an2", {28'd0, an}, 32'h0000000B);
        repeat (4) @(negedge clk);
        chk("scan_an3", {28'd0, an}, 32'h00000007);
        repeat (4) @(negedge clk);
        chk("scan_an0", {28'd0, an}, 32'h0000000E);
        $display("scan: stepping checked");

        // -45
        do_load(8'hD3, 1'b1, "d3s");
        check_display("d3s", MIN, BLANK_EN ? BLK : seg_tab[0], seg_tab[4], seg_tab[5]);
        // 195 unsigned
        do_load(8'hC3, 1'b0, "c3u");
        check_display("c3u", BLK, seg_tab[1], seg_tab[9], seg_tab[5]);
        // 255 unsigned
        do_load(8'hFF, 1'b0, "ffu");
        check_display("ffu", BLK, seg_tab[2], seg_tab[5], seg_tab[5]);
        // -128
        do_load(8'h80, 1'b1, "80s");
        check_display("80s", MIN, seg_tab[1], seg_tab[2], seg_tab[8]);
        // 0
        do_load(8'h00, 1'b1, "00s");
        check_display("00s", BLK, BLANK_EN ? BLK : seg_tab[0], BLANK_EN ? BLK : seg_tab[0], seg_tab[0]);

        // Load 7, then a second load at edge k+4 must be ignored.
        @(negedge clk); fu = 8'h07; sgn = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        dc = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 3) begin
                fu = 8'h09; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (done === 1'b1) dc++;
            @(negedge clk);
        end
        chk("ignore_done_count", dc, 1);
        $display("load 07 with ignored 09: done pulses=%0d", dc);
        check_display("07u", BLK, BLANK_EN ? BLK : seg_tab[0], BLANK_EN ? BLK : seg_tab[0], seg_tab[7]);

        // Reset in the middle of a conversion.
        @(negedge clk); fu = 8'hC3; sgn = 1'b0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_an", {28'd0, an}, 32'h0000000E);
        chk("abort_seg", {25'd0, seg}, 32'h00000040);
        dc = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) dc++;
            @(negedge clk);
        end
        chk("abort_no_done", dc, 0);
        $display("reset mid-conversion: busy=%b done pulses=%0d", busy, dc);
        check_display("abort", BLK, BLANK_EN ? BLK : seg_tab[0], BLANK_EN ? BLK : seg_tab[0], seg_tab[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
